// File: rtl/register_en.sv
// N-bit storage register: synchronous active-low reset, synchronous write enable.
// Q comes straight from the storage flops, so there is no combinational path from D to Q.
module register_en #(
    parameter int            N           = 24,
    parameter logic [N-1:0]  RESET_VALUE = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    logic [N-1:0] q_r;

    // Storage flops: reset beats enable, and enable beats hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= RESET_VALUE;
        end else if (en) begin
            q_r <= D;
        end else begin
            q_r <= q_r;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_register_en.sv
// Directed bench for register_en: the default 24-bit instance plus an 8-bit instance
// with a non-zero reset value.
module tb_register_en;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] d24;
    logic [23:0] q24;
    logic [7:0]  d8;
    logic [7:0]  q8;
    int          checks;
    int          errors;

    register_en #(.N(24)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .D   (d24),
        .Q   (q24)
    );

    register_en #(.N(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .D   (d8),
        .Q   (q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check24(input string tag, input logic [23:0] exp);
        checks++;
        assert (q24 === exp) else begin
            errors++;
            $error("FAIL %s: Q=%06h expected %06h", tag, q24, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] exp);
        checks++;
        assert (q8 === exp) else begin
            errors++;
            $error("FAIL %s: Q8=%02h expected %02h", tag, q8, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b0;
        d24 = 24'h011111;
        d8  = 8'h3C;
        #2;

        // Reset with enable low.
        rst = 1'b0;
        tick();
        check24("reset", 24'h000000);
        check8("reset8", 8'hA5);
        rst = 1'b1;
        tick();
        check24("release_hold", 24'h000000);
        check8("release_hold8", 8'hA5);

        // Enabled write, then hold while D changes.
        en = 1'b1;
        tick();
        check24("write1", 24'h011111);
        check8("write8", 8'h3C);
        en  = 1'b0;
        d24 = 24'h0AAAAA;
        d8  = 8'hC3;
        tick();
        check24("hold_a", 24'h011111);
        tick();
        check24("hold_b", 24'h011111);
        tick();
        check24("hold_c", 24'h011111);
        check8("hold8", 8'h3C);

        // Overwrite, then re-pulse with same data.
        en = 1'b1;
        tick();
        check24("overwrite", 24'h0AAAAA);
        check8("overwrite8", 8'hC3);
        tick();
        check24("repulse", 24'h0AAAAA);

        // Reset wins over a pending write.
        rst = 1'b0;
        d24 = 24'h044444;
        tick();
        check24("rst_prio", 24'h000000);
        check8("rst_prio8", 8'hA5);
        rst = 1'b1;
        tick();
        check24("post_rst_write", 24'h044444);

        // Streaming with enable held high.
        d24 = 24'h077777;
        tick();
        check24("stream_7", 24'h077777);
        d24 = 24'h022222;
        tick();
        check24("stream_2", 24'h022222);
        en  = 1'b0;
        d24 = 24'h0EEEEE;
        tick();
        check24("stream_hold_e", 24'h022222);
        d24 = 24'h000000;
        tick();
        check24("stream_hold_0", 24'h022222);

        // Toggle rst / D / en between edges: Q must not move mid-cycle.
        rst = 1'b0;
        #2;
        check24("mid_rst", 24'h022222);
        d24 = 24'h055555;
        en  = 1'b1;
        #2;
        check24("mid_d", 24'h022222);
        rst = 1'b1;
        #2;
        check24("mid_release", 24'h022222);
        tick();
        check24("edge_write", 24'h055555);

        // Final reset with enable high clears both widths.
        rst = 1'b0;
        tick();
        check24("final_rst", 24'h000000);
        check8("final_rst8", 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
